// File: rtl/priority_scan_pkg.sv
// Shared types and helpers for the priority bit scanner and its position finder.
package priority_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // Position width for a vector of w bits; never narrower than one bit.
   function automatic int pos_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/priority_pos_find.sv
// Combinational priority encoder: position of the lowest (or highest) set bit,
// plus flags for "any bit set" and "exactly one bit set".
module priority_pos_find
   import priority_scan_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int POS_W    = pos_width(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [POS_W-1:0] pos,
   output logic             any,
   output logic             single
);

   // The last match written wins, so the scan direction picks the priority end.
   generate
      if (MSB_FIRST) begin : g_msb
         always_comb begin
            pos = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (vec[i]) pos = POS_W'(i);
            end
         end
      end else begin : g_lsb
         always_comb begin
            pos = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (vec[i]) pos = POS_W'(i);
            end
         end
      end
   endgenerate

   assign any    = |vec;
   assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_bit_scanner.sv
// Accepts a vector over valid/ready and streams out the position of each set bit,
// one beat per bit (a single "none" beat for an all-zero vector).
module priority_bit_scanner
   import priority_scan_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int POS_W    = pos_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic [POS_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none
);

   scan_state_t      state_reg;
   logic [WIDTH-1:0] residual_reg;
   logic [POS_W-1:0] idx_reg;
   logic             none_reg;

   logic [POS_W-1:0] find_pos;
   logic             find_any;
   logic             find_single;
   logic [WIDTH-1:0] clr_mask;
   logic             beat;
   logic             accept;

   priority_pos_find #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_find (
      .vec    (residual_reg),
      .pos    (find_pos),
      .any    (find_any),
      .single (find_single)
   );

   // One-hot of the bit being emitted, used to retire it from the residual.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clr
         assign clr_mask[gi] = (find_pos == POS_W'(gi));
      end
   endgenerate

   assign out_valid = (state_reg == SCAN);
   assign out_pos   = find_any ? find_pos : '0;
   assign out_idx   = idx_reg;
   assign out_none  = none_reg;
   assign out_last  = none_reg || find_single;

   assign beat     = out_valid && out_ready;
   assign in_ready = !out_valid || (beat && out_last);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         residual_reg <= '0;
         idx_reg      <= '0;
         none_reg     <= 1'b0;
      end else if (accept) begin
         // Covers both the idle load and the gapless reload on a last beat.
         state_reg    <= SCAN;
         residual_reg <= in_data;
         idx_reg      <= '0;
         none_reg     <= (in_data == '0);
      end else if (beat) begin
         if (out_last) begin
            state_reg <= IDLE;
         end else begin
            residual_reg <= residual_reg & ~clr_mask;
            idx_reg      <= idx_reg + POS_W'(1);
         end
      end
   end

endmodule

// File: doc/priority_bit_scanner.md
Name: priority_bit_scanner

Overview:
Parametrised, sequential successor to the team's 8-bit combinational lowest-set-bit encoder. It accepts a WIDTH-bit vector over a valid/ready handshake and emits the position of every set bit, one per output beat. Order is lowest-first by default, or highest-first when MSB_FIRST=1. It sits between request-vector producers (interrupt/arbiter status) and per-index consumers that need to service each set bit in turn.

Parameters:
WIDTH, 8, width of the input vector; must be at least 2.
MSB_FIRST, 0, 0 = emit lowest set bit first; 1 = emit highest set bit first.
POS_W, $clog2(WIDTH), width of the position and beat-index outputs (derived; not overridden).

Ports:
clk  input  1  the block's single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data is valid.
in_ready  output  1  block accepts in_data this cycle.
in_data  input  WIDTH  vector to scan.
out_valid  output  1  out_pos, out_idx, out_last and out_none are valid.
out_ready  input  1  consumer takes the current beat.
out_pos  output  POS_W  bit position of the current set bit.
out_idx  output  POS_W  beat index within the current vector, starting at 0.
out_last  output  1  current beat is the final beat of this vector.
out_none  output  1  accepted vector was all-zero; only beat, with out_pos=0.

Behaviour:
- Reset (synchronous, active-high, on a clk edge while reset=1):
  - State goes to IDLE, residual register clears to 0, idx clears to 0, none flag clears.
  - After reset, out_valid=0 and in_ready=1.
  - Handshakes in a cycle where reset=1 are ignored.
  - Reset mid-scan abandons the vector; out_valid=0 from the next cycle.
- States:
  - IDLE: out_valid=0.
  - SCAN: out_valid=1.
- Input acceptance:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Accept = in_valid && in_ready.
- On accept:
  - residual <= in_data, idx <= 0, state <= SCAN.
  - none <= (in_data==0).
  - First beat appears the next cycle (latency 1).
- In SCAN:
  - out_pos = priority position of residual (lowest or highest set bit per MSB_FIRST); 0 when none=1.
  - out_last = none || (exactly one bit set in residual).
  - out_idx = idx.
- Beat handshake (out_valid && out_ready):
  - Not last: clear bit out_pos in residual, idx <= idx+1, stay in SCAN.
  - Last with no simultaneous accept: state <= IDLE.
  - Last with simultaneous accept: load the new vector and remain in SCAN, giving gapless back-to-back vectors.
- Backpressure: while out_valid && !out_ready, every output holds stable and in_ready=0.
- Beats per vector: popcount(in_data) when nonzero, otherwise exactly one (none=1). The maximum is WIDTH beats, so out_idx never wraps.
- All outputs are driven from registered state plus combinational decode of residual. No combinational path from in_data to the out_* signals.

Decomposition:
- Shared package priority_scan_pkg: state enum {IDLE, SCAN}; helper localparam function for POS_W.
- One combinational sub-module, priority_pos_find:
  - Parameters WIDTH, MSB_FIRST.
  - Inputs: vec.
  - Outputs: pos, any, single.
  - Generalises the existing 8-bit encoder and is reusable elsewhere.

Test Plan:
- Lowest-first order: WIDTH=8, MSB_FIRST=0, out_ready=1, accept in_data=8'b1010_0100 -> out_pos 2,5,7 on three consecutive cycles; out_idx 0,1,2; out_last only on pos 7; in_ready=1 on that cycle.
- All-zero input: accept 8'h00 -> one beat with out_none=1, out_pos=0, out_last=1, out_idx=0, then IDLE.
- Backpressure: 8'b0001_1000 with out_ready=0 for 3 cycles -> out_pos=3 and out_idx=0 held stable, in_ready=0; then out_ready=1 -> 3 then 4.
- Back-to-back: during the last beat of 8'h01, present in_valid with 8'h80 -> accepted that same cycle; next cycle out_pos=7, out_idx=0, with no idle gap.
- MSB-first and wider vector: MSB_FIRST=1, WIDTH=16, 16'h8421 -> out_pos 15,10,5,0; 16'hFFFF -> 16 beats, out_idx 0..15, out_last at idx 15.
- Reset mid-scan: assert reset after the first beat of 8'hFF -> next cycle out_valid=0, in_ready=1; a new 8'h02 vector yields a single beat, out_pos=1, out_idx=0.
